mem_responder: RTL and testbench
================================

// Module: mem_responder
// PURPOSE
//   Memory-side responder for the multicycle core's unified memory port.
//   Accepts one word-addressed read/write request from the core (Adr, WriteData, byteEnable).
//   Stalls for a programmable number of wait states, then commits the access.
//   Returns a full 32-bit word with a one-cycle ready pulse; the core's memextend does byte/half extraction.
// PARAMETERS
//   DEPTH_WORDS   1024  storage depth in 32-bit words; power of two, >= 2
//   WAIT_STATES   2     extra cycles between accept and commit; 0..15
// PORTS
//   clk      in   1   clock; all state on rising edge
//   reset    in   1   asynchronous, active-low reset
//   req      in   1   request valid; initiator holds it until ready
//   we       in   1   1 = write, 0 = read
//   adr      in   32  byte address; adr[1:0] ignored
//   be       in   4   byte-lane enables for writes; lane i = wdata[8i+7:8i]
//   wdata    in   32  write data, already lane-aligned by the core
//   rdata    out  32  read data; valid while ready=1
//   ready    out  1   one-cycle completion pulse
//   busy     out  1   1 whenever state != IDLE
//   err      out  1   qualifies ready; address out of range
// BEHAVIOUR
//   Reset (reset=0, async):
//     - State -> IDLE; rdata, ready, busy, err, wait counter -> 0.
//     - Storage contents are not reset.
//   FSM states: IDLE, WAIT, RESP.
//   IDLE, req=1 (accept):
//     - Latch adr, we, be, wdata.
//     - Load counter = WAIT_STATES.
//     - Go to WAIT if WAIT_STATES>0; else commit and go to RESP.
//   WAIT:
//     - Counter decrements each cycle.
//     - Counter==1: commit on this edge and go to RESP.
//     - req/inputs are ignored; latched values are used.
//   Commit:
//     - Word index = latched adr[log2(DEPTH_WORDS)+1:2].
//     - Out of range = any latched adr[31:log2(DEPTH_WORDS)+2] nonzero.
//     - Write: each lane with be[i]=1 is updated; be=4'b0000 is a legal no-op.
//     - Read: rdata <= mem[index], whole word regardless of be.
//     - Write: rdata <= 0.
//     - Out of range: no storage update, rdata <= 0, err <= 1.
//   RESP:
//     - ready=1 (err as set at commit) for exactly one cycle, then go to IDLE.
//     - ready, err and rdata return to 0 on the next edge.
//   Latency: accept edge to ready-high cycle = WAIT_STATES+1 cycles.
//   Back-to-back:
//     - req held high through RESP does not re-accept in RESP.
//     - Next accept occurs in the following IDLE cycle.
//     - Minimum issue interval = WAIT_STATES+2 cycles.
//   Reset mid-operation:
//     - If asserted before the commit edge, the pending write is dropped and memory is unchanged.
//     - If asserted after commit, the write is retained.
//   Read-after-write to the same word in consecutive requests returns the new data.
// TESTING
//   1. WAIT_STATES=2: write adr=0x10, be=4'b1111, wdata=0xDEADBEEF -> ready 3 cycles after accept, err=0.
//      Then read 0x10 -> rdata=0xDEADBEEF.
//   2. Byte lanes: after test 1, write 0x10 with be=4'b0010, wdata=0x0000AA00 -> read 0x10 = 0xDEADAAEF.
//      Write with be=0 -> unchanged.
//   3. Out of range: DEPTH_WORDS=1024, read adr=0x00001000 -> ready with err=1, rdata=0.
//      Write there -> err=1; index 0 unchanged.
//   4. req held high continuously for 3 reads -> exactly 3 ready pulses spaced WAIT_STATES+2=4 cycles apart.
//      adr/wdata changes during WAIT have no effect.
//   5. Reset mid-op: write 0x20=0x12345678, assert reset in the WAIT cycle before commit.
//      -> ready/busy=0 immediately; later read 0x20 returns the old value.
//   6. WAIT_STATES=0: write then read 0x04 -> each ready 1 cycle after accept; read returns written data.

Source files
------------

// File: rtl/mem_responder.sv
// Memory-side responder for the multicycle core's unified memory port.
// Latches one word-addressed request, waits WAIT_STATES cycles, commits, then pulses ready.
module mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] adr,
    input  logic [3:0]  be,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        busy,
    output logic        err
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;
    logic          we_q, we_d;
    logic          ready_q, ready_d;
    logic          err_q, err_d;
    logic          rsel_q, rsel_d;
    logic [31:0]   mem_rd_q;
    logic [31:0]   mem [DEPTH_WORDS];

    logic          commit;
    logic [31:0]   c_adr, c_wdata;
    logic [3:0]    c_be;
    logic          c_we;
    logic          c_oob;
    logic [AW-1:0] c_idx;

    // With zero wait states the commit happens on the accept edge, straight from the inputs.
    assign c_adr   = (state_q == S_IDLE) ? adr   : adr_q;
    assign c_wdata = (state_q == S_IDLE) ? wdata : wdata_q;
    assign c_be    = (state_q == S_IDLE) ? be    : be_q;
    assign c_we    = (state_q == S_IDLE) ? we    : we_q;
    assign c_oob   = (c_adr >> (AW + 2)) != 32'd0;
    assign c_idx   = c_adr[AW+1:2];

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        we_d    = we_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        rsel_d  = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (req && reset) begin
                    adr_d   = adr;
                    wdata_d = wdata;
                    be_d    = be;
                    we_d    = we;
                    cnt_d   = WS;
                    if (WS == 4'd0) begin
                        commit  = 1'b1;
                        state_d = S_RESP;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    commit  = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (commit) begin
            ready_d = 1'b1;
            err_d   = c_oob;
            rsel_d  = !c_oob && !c_we;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            adr_q   <= 32'd0;
            wdata_q <= 32'd0;
            be_q    <= 4'd0;
            we_q    <= 1'b0;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
            rsel_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            adr_q   <= adr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            we_q    <= we_d;
            ready_q <= ready_d;
            err_q   <= err_d;
            rsel_q  <= rsel_d;
        end
    end

    // NOTE: storage and its read register carry no reset so they map onto plain RAM.
    always_ff @(posedge clk) begin
        if (commit && !c_oob) begin
            if (c_we) begin
                for (int i = 0; i < 4; i++) begin
                    if (c_be[i]) mem[c_idx][8*i +: 8] <= c_wdata[8*i +: 8];
                end
            end else begin
                mem_rd_q <= mem[c_idx];
            end
        end
    end

    assign rdata = rsel_q ? mem_rd_q : 32'd0;
    assign ready = ready_q;
    assign err   = err_q;
    assign busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: two instances (2 and 0 wait states) driven with
// directed and random requests, checked against a word-array reference model.
module tb_mem_responder;
    localparam int DEPTH = 1024;
    localparam int WS0   = 2;
    localparam int WS1   = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic [1:0]       req, we, ready, busy, err;
    logic [1:0][31:0] adr, wdata, rdata;
    logic [1:0][3:0]  be;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        sb0[$];
    exp_t        sb1[$];
    logic [31:0] rm [2][DEPTH];
    bit          resp_now [2];
    logic [1:0]  ready_prev;

    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS0)) u_dut0 (
        .clk(clk), .reset(reset), .req(req[0]), .we(we[0]), .adr(adr[0]), .be(be[0]),
        .wdata(wdata[0]), .rdata(rdata[0]), .ready(ready[0]), .busy(busy[0]), .err(err[0])
    );

    mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(WS1)) u_dut1 (
        .clk(clk), .reset(reset), .req(req[1]), .we(we[1]), .adr(adr[1]), .be(be[1]),
        .wdata(wdata[1]), .rdata(rdata[1]), .ready(ready[1]), .busy(busy[1]), .err(err[1])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic int ws(int d);
        return (d == 0) ? WS0 : WS1;
    endfunction

    // Reference: byte-addressed words, anything at or beyond DEPTH words is an error.
    task automatic model(int d, bit w, logic [31:0] a, logic [3:0] b, logic [31:0] wd, output exp_t e);
        int idx;
        e.rdata = 32'd0;
        e.err   = 1'b0;
        e.cyc   = 0;
        if (a >= 32'(DEPTH * 4)) begin
            e.err = 1'b1;
        end else begin
            idx = int'(a / 4);
            if (w) begin
                for (int i = 0; i < 4; i++)
                    if (b[i]) rm[d][idx][8*i +: 8] = wd[8*i +: 8];
            end else begin
                e.rdata = rm[d][idx];
            end
        end
    endtask

    // Called at a falling edge; leaves req high so a following call is back-to-back.
    task automatic do_req(int d, bit w, logic [31:0] a, logic [3:0] b, logic [31:0] wd, bit scr);
        exp_t e;
        int   n;
        model(d, w, a, b, wd, e);
        e.cyc = cyc + (resp_now[d] ? 2 : 1) + ws(d);
        if (d == 0) sb0.push_back(e); else sb1.push_back(e);
        req[d] = 1'b1; we[d] = w; adr[d] = a; be[d] = b; wdata[d] = wd;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (scr && busy[d] && !ready[d]) begin
                we[d]    = 1'($urandom);
                adr[d]   = $urandom;
                be[d]    = 4'($urandom);
                wdata[d] = $urandom;
            end
        end while (!ready[d] && n < 50);
        if (!ready[d]) begin
            checks++;
            errors++;
            $display("FAIL timeout[%0d]: ready still 0 after %0d cycles, required 1", d, n);
        end
        resp_now[d] = 1'b1;
    endtask

    task automatic idle(int d, int n);
        req[d] = 1'b0;
        repeat (n) @(negedge clk);
        resp_now[d] = 1'b0;
    endtask

    function automatic logic [31:0] rand_adr();
        if ($urandom_range(0, 7) == 0)
            return ($urandom_range(1, 32'h000F_FFFF) << 12) | ($urandom & 32'hFFF);
        return 32'($urandom_range(0, 15) * 4) | ($urandom & 32'h3);
    endfunction

    // Monitor: pops one expectation per ready pulse, and checks outputs clear afterwards.
    initial begin
        exp_t e;
        ready_prev = '0;
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (ready[d]) begin
                    if ((d == 0 ? sb0.size() : sb1.size()) == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_ready[%0d]: ready=1 with nothing outstanding", d);
                    end else begin
                        if (d == 0) e = sb0.pop_front(); else e = sb1.pop_front();
                        check($sformatf("rdata[%0d]", d), rdata[d], e.rdata);
                        check($sformatf("err[%0d]", d), 32'(err[d]), 32'(e.err));
                        check($sformatf("ready_cycle[%0d]", d), 32'(cyc), 32'(e.cyc));
                    end
                end else if (ready_prev[d]) begin
                    check($sformatf("rdata_clear[%0d]", d), rdata[d], 32'd0);
                    check($sformatf("err_clear[%0d]", d), 32'(err[d]), 32'd0);
                end
                ready_prev[d] = ready[d];
            end
        end
    end

    initial begin
        reset = 1'b0;
        req = '0; we = '0; adr = '0; be = '0; wdata = '0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset_ready[%0d]", d), 32'(ready[d]), 32'd0);
            check($sformatf("reset_busy[%0d]", d), 32'(busy[d]), 32'd0);
            check($sformatf("reset_err[%0d]", d), 32'(err[d]), 32'd0);
            check($sformatf("reset_rdata[%0d]", d), rdata[d], 32'd0);
        end
        reset = 1'b1;
        @(negedge clk);

        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 16; i++) begin
                do_req(d, 1'b1, 32'(i * 4), 4'hF, $urandom, 1'b0);
                idle(d, 1);
            end
        end

        do_req(0, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 1'b0); idle(0, 1);
        do_req(0, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0);         idle(0, 1);
        do_req(0, 1'b1, 32'h10, 4'b0010, 32'h0000_AA00, 1'b0); idle(0, 1);
        do_req(0, 1'b0, 32'h10, 4'hF, 32'h0, 1'b0);         idle(0, 1);
        do_req(0, 1'b1, 32'h10, 4'h0, 32'h5555_5555, 1'b0); idle(0, 1);
        do_req(0, 1'b0, 32'h10, 4'h0, 32'h0, 1'b0);         idle(0, 2);

        do_req(0, 1'b0, 32'h0000_1000, 4'hF, 32'h0, 1'b0);         idle(0, 1);
        do_req(0, 1'b1, 32'h0000_1000, 4'hF, 32'h0BAD_0BAD, 1'b0); idle(0, 1);
        do_req(0, 1'b0, 32'h0, 4'hF, 32'h0, 1'b0);                 idle(0, 2);

        do_req(0, 1'b0, 32'h10, 4'hF, 32'h0, 1'b1);
        do_req(0, 1'b0, 32'h14, 4'hF, 32'h0, 1'b1);
        do_req(0, 1'b0, 32'h18, 4'hF, 32'h0, 1'b1);
        idle(0, 2);

        req[0] = 1'b1; we[0] = 1'b1; adr[0] = 32'h20; be[0] = 4'hF; wdata[0] = 32'h1234_5678;
        @(negedge clk);
        check("busy_after_accept", 32'(busy[0]), 32'd1);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_mid_ready", 32'(ready[0]), 32'd0);
        check("reset_mid_busy", 32'(busy[0]), 32'd0);
        req[0] = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        idle(0, 2);
        do_req(0, 1'b0, 32'h20, 4'hF, 32'h0, 1'b0); idle(0, 2);

        do_req(1, 1'b1, 32'h04, 4'hF, 32'hCAFE_F00D, 1'b0); idle(1, 1);
        do_req(1, 1'b0, 32'h04, 4'hF, 32'h0, 1'b0);
        do_req(1, 1'b1, 32'h04, 4'b1001, 32'h1100_0022, 1'b0);
        do_req(1, 1'b0, 32'h04, 4'h0, 32'h0, 1'b0);
        idle(1, 2);

        for (int d = 0; d < 2; d++) begin
            repeat (80) begin
                do_req(d, 1'($urandom), rand_adr(), 4'($urandom), $urandom, 1'b1);
                if ($urandom_range(0, 1) == 1) idle(d, $urandom_range(1, 3));
            end
            idle(d, 2);
        end

        repeat (5) @(negedge clk);
        check("sb0_drained", 32'(sb0.size()), 32'd0);
        check("sb1_drained", 32'(sb1.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
